tdc_tapped_line_channel: RTL and testbench

- Parametrised successor to the single-chain MUX delay line.
- Builds an NTAPS-deep carry-style tap chain from the MUX primitive cell (A = previous tap, B = 0, S = 1).
- Samples the whole chain every clock and detects hit rising edges.
- Emits one timestamp per hit: free-running coarse count plus a bubble-tolerant fine code.
- Sits between the hit filter and the readout FIFO, one instance per TDC channel.

---
 rtl/tdc_tapped_line_channel.sv | 194 +++++++++++++++++++
 tb/tb_tdc_tapped_line_channel.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_tapped_line_channel.sv
// Tapped MUX delay-line TDC channel: samples an NTAPS-deep carry-style chain every clock
// and emits one timestamp (coarse count + popcount fine code) per accepted hit rising edge.

module tdc_mux_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);
  assign y_o = s_i ? a_i : b_i;
endmodule

module tdc_tapped_line_channel #(
  parameter int NTAPS       = 64,
  parameter int COARSE_W    = 16,
  parameter int FINE_W      = $clog2(NTAPS + 1),
  parameter int DEAD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                filtered_hit,
  input  logic                enable,
  output logic                tdc_valid,
  output logic [COARSE_W-1:0] tdc_coarse,
  output logic [FINE_W-1:0]   tdc_fine,
  output logic                tdc_sat,
  output logic                hit_lost,
  output logic                busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DEAD = 1'b1
  } state_e;

  // Valid/ready note: there is no back-pressure; tdc_valid is a one-cycle strobe and the
  // timestamp fields stay stable until the next strobe, so the consumer must take it that cycle.

  logic [NTAPS-1:0] tap_w;
  logic [NTAPS-1:0] snap_w;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic a_w;
    logic z_w;
    if (k == 0) begin : g_first
      assign a_w = filtered_hit;
    end else begin : g_next
      assign a_w = g_tap[k-1].z_w;
    end
    (* keep = "true", dont_touch = "true" *)
    tdc_mux_cell u_cell (
      .a_i (a_w),
      .b_i (1'b0),
      .s_i (1'b1),
      .y_o (z_w)
    );
    assign tap_w[k] = z_w;
  end

  assign snap_w = tap_w;

  function automatic logic [FINE_W-1:0] popcount(input logic [NTAPS-1:0] v);
    logic [FINE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NTAPS; i++) begin
      c = c + FINE_W'(v[i]);
    end
    return c;
  endfunction

  logic [COARSE_W-1:0] coarse_cnt_q, coarse_cnt_d;
  logic [NTAPS-1:0]    s1_taps_q, s2_taps_q;
  logic [COARSE_W-1:0] s1_coarse_q, s2_coarse_q;
  logic                prev_tap0_q;
  state_e              state_q, state_d;
  logic [7:0]          dead_cnt_q, dead_cnt_d;
  logic                hit_lost_q, hit_lost_d;
  logic                s3_valid_q;
  logic [COARSE_W-1:0] s3_coarse_q;
  logic [FINE_W-1:0]   s3_fine_q;
  logic                s3_sat_q;
  logic                out_valid_q;
  logic [COARSE_W-1:0] out_coarse_q;
  logic [FINE_W-1:0]   out_fine_q;
  logic                out_sat_q;

  logic                s2_tap0;
  logic                rise;
  logic                detect;
  logic [FINE_W-1:0]   s2_pop;
  logic                s4_load;

  assign s2_tap0 = s2_taps_q[0];
  assign rise    = s2_tap0 & ~prev_tap0_q;
  assign detect  = rise & enable & (state_q == ST_IDLE);
  assign s2_pop  = popcount(s2_taps_q);
  // An enable drop aborts a timestamp still sitting in S3.
  assign s4_load = s3_valid_q & enable;

  assign coarse_cnt_d = enable ? coarse_cnt_q + COARSE_W'(1) : '0;

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    hit_lost_d = hit_lost_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      dead_cnt_d = '0;
      hit_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (detect) begin
            state_d    = ST_DEAD;
            dead_cnt_d = 8'(DEAD_CYCLES);
          end
        end
        ST_DEAD: begin
          if (rise) begin
            hit_lost_d = 1'b1;
          end
          if (dead_cnt_q != 8'd0) begin
            dead_cnt_d = dead_cnt_q - 8'd1;
          end
          // Leave dead time only once the window has expired and the hit has fallen.
          if ((dead_cnt_q <= 8'd1) && !s2_tap0) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_cnt_q <= '0;
      s1_taps_q    <= '0;
      s1_coarse_q  <= '0;
      s2_taps_q    <= '0;
      s2_coarse_q  <= '0;
      prev_tap0_q  <= 1'b0;
      state_q      <= ST_IDLE;
      dead_cnt_q   <= '0;
      hit_lost_q   <= 1'b0;
    end else begin
      coarse_cnt_q <= coarse_cnt_d;
      s1_taps_q    <= snap_w;
      s1_coarse_q  <= coarse_cnt_q;
      s2_taps_q    <= s1_taps_q;
      s2_coarse_q  <= s1_coarse_q;
      prev_tap0_q  <= s2_tap0;
      state_q      <= state_d;
      dead_cnt_q   <= dead_cnt_d;
      hit_lost_q   <= hit_lost_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q   <= 1'b0;
      s3_coarse_q  <= '0;
      s3_fine_q    <= '0;
      s3_sat_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_coarse_q <= '0;
      out_fine_q   <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      s3_valid_q  <= detect;
      if (detect) begin
        s3_coarse_q <= s2_coarse_q;
        s3_fine_q   <= s2_pop;
        s3_sat_q    <= (s2_pop == FINE_W'(NTAPS));
      end
      out_valid_q <= s4_load;
      if (s4_load) begin
        out_coarse_q <= s3_coarse_q;
        out_fine_q   <= s3_fine_q;
        out_sat_q    <= s3_sat_q;
      end
    end
  end

  assign tdc_valid  = out_valid_q;
  assign tdc_coarse = out_coarse_q;
  assign tdc_fine   = out_fine_q;
  assign tdc_sat    = out_sat_q;
  assign hit_lost   = hit_lost_q;
  assign busy       = (state_q == ST_DEAD);

endmodule

// File: tb/tb_tdc_tapped_line_channel.sv
// Directed bench for tdc_tapped_line_channel: table of single-hit captures plus hand-written
// sequences for reset, dead time, enable abort and coarse wrap.

module tb_tdc_tapped_line_channel;

  logic        clk;
  logic        rst_n;
  logic        hit;
  logic        enable;
  logic        valid;
  logic [15:0] coarse;
  logic [6:0]  fine;
  logic        sat;
  logic        lost;
  logic        busy;

  logic        hit_w;
  logic        enable_w;
  logic        valid_w;
  logic [3:0]  coarse_w;
  logic [6:0]  fine_w;
  logic        sat_w;
  logic        lost_w;
  logic        busy_w;

  int          checks;
  int          errors;
  logic [63:0] force_val;
  logic [3:0]  exp_q[$];

  tdc_tapped_line_channel #(
    .NTAPS       (64),
    .COARSE_W    (16),
    .DEAD_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .filtered_hit (hit),
    .enable       (enable),
    .tdc_valid    (valid),
    .tdc_coarse   (coarse),
    .tdc_fine     (fine),
    .tdc_sat      (sat),
    .hit_lost     (lost),
    .busy         (busy)
  );

  tdc_tapped_line_channel #(
    .NTAPS       (64),
    .COARSE_W    (4),
    .DEAD_CYCLES (1)
  ) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .filtered_hit (hit_w),
    .enable       (enable_w),
    .tdc_valid    (valid_w),
    .tdc_coarse   (coarse_w),
    .tdc_fine     (fine_w),
    .tdc_sat      (sat_w),
    .hit_lost     (lost_w),
    .busy         (busy_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          coarse_at;
    bit          use_force;
    logic [63:0] snap;
    int          hold;
    logic [15:0] exp_coarse;
    logic [6:0]  exp_fine;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Hit must have just been raised at a negedge; the next posedge is the capture edge.
  task automatic check_capture(input string tag, input logic [15:0] exp_coarse,
                               input logic [6:0] exp_fine, input logic exp_sat,
                               input int hold, input bit forced);
    int budget;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0 && forced) release dut.snap_w;
      if (c == hold - 1) hit = 1'b0;
      chk($sformatf("%s_valid_c%0d", tag, c), valid, (c == 3) ? 1 : 0);
      if (c == 3) begin
        chk({tag, "_coarse"}, coarse, exp_coarse);
        chk({tag, "_fine"}, fine, exp_fine);
        chk({tag, "_sat"}, sat, exp_sat);
        chk({tag, "_busy"}, busy, 1);
      end
    end
    hit = 1'b0;
    budget = 0;
    while (busy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_busy_clears"}, busy, 0);
  endtask

  task automatic restart_enable();
    hit    = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    int vcnt;
    int bcnt;
    int first_v;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    hit      = 1'b0;
    enable   = 1'b0;
    hit_w    = 1'b0;
    enable_w = 1'b0;
    force_val = '0;

    vecs[0] = '{100, 1'b1, 64'h0000_0000_000F_FFFF, 3, 16'd100, 7'd20, 1'b0};
    vecs[1] = '{37,  1'b1, 64'h0000_0000_3FFF_EFFF, 1, 16'd37,  7'd29, 1'b0};
    vecs[2] = '{5,   1'b0, 64'h0,                   6, 16'd5,   7'd64, 1'b1};
    vecs[3] = '{0,   1'b1, 64'h0000_0000_0000_0001, 2, 16'd0,   7'd1,  1'b0};
    vecs[4] = '{250, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 2, 16'd250, 7'd63, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_coarse", coarse, 0);
    chk("rst_fine", fine, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_valid", valid_w, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single captures
    for (int i = 0; i < 5; i++) begin
      restart_enable();
      repeat (vecs[i].coarse_at) @(negedge clk);
      hit = 1'b1;
      if (vecs[i].use_force) begin
        force_val = vecs[i].snap;
        force dut.snap_w = force_val;
      end
      check_capture($sformatf("vec%0d", i), vecs[i].exp_coarse, vecs[i].exp_fine,
                    vecs[i].exp_sat, vecs[i].hold, vecs[i].use_force);
    end

    // reset mid-flight with hit high: outputs drop at once, no partial valid afterwards
    restart_enable();
    hit = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_coarse", coarse, 0);
    chk("mid_rst_fine", fine, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_lost", lost, 0);
    chk("mid_rst_busy", busy, 0);
    hit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("post_rst_no_valid", vcnt, 0);
    hit = 1'b1;
    check_capture("post_rst", 16'd8, 7'd64, 1'b1, 2, 1'b0);

    // dead time: two 1-cycle hits two clocks apart
    restart_enable();
    hit = 1'b1;
    vcnt = 0;
    bcnt = 0;
    first_v = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
      end
      if (busy) bcnt++;
      hit = (c == 1);
    end
    chk("dead_valid_count", vcnt, 1);
    chk("dead_valid_cycle", first_v, 3);
    chk("dead_busy_cycles", bcnt, 4);
    chk("dead_hit_lost", lost, 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dead_lost_cleared", lost, 0);

    // enable drop one clock after capture aborts the timestamp
    restart_enable();
    hit = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lost", lost, 0);
    enable = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("reenable_held_no_valid", vcnt, 0);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    hit = 1'b1;
    check_capture("reenable_edge", 16'd11, 7'd64, 1'b1, 2, 1'b0);

    // coarse wrap on the 4-bit, DEAD_CYCLES=1 instance
    enable_w = 1'b1;
    repeat (15) @(negedge clk);
    hit_w = 1'b1;
    exp_q.push_back(4'd15);
    exp_q.push_back(4'd1);
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hit_w = (c == 1);
      if (valid_w) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          chk("wrap_unexpected_valid", 1, 0);
        end else begin
          chk($sformatf("wrap_coarse_%0d", vcnt), coarse_w, exp_q.pop_front());
          chk($sformatf("wrap_fine_%0d", vcnt), fine_w, 64);
          chk($sformatf("wrap_sat_%0d", vcnt), sat_w, 1);
        end
      end
    end
    chk("wrap_valid_count", vcnt, 2);
    chk("wrap_lost", lost_w, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
